// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Multi-cycle control unit for the MIPS core. Each instruction is walked
// through FETCH / DECODE / (MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BRANCH,
// JUMP, ADDIEX, ADDIWB) so the datapath can share one ALU and one memory port.
// Memory accesses stall on i_MemReady. A memory access that waits too long
// traps into a sticky FAULT state. An unsupported opcode raises a one-cycle
// o_Illegal pulse and restarts at FETCH. Every completed instruction
// increments a wrapping retired-instruction counter.
//
// Parameters
//   CNT_W        width of the retired-instruction counter
//   MEM_TIMEOUT  maximum consecutive wait cycles per memory access (0 = off)
//
// Ports
//   i_Clk, i_Rst_n         clock, asynchronous active-low reset
//   i_Opcode               instruction[31:26], sampled in DECODE
//   i_Zero                 ALU zero flag (branch resolution)
//   i_MemReady             memory completes the current request this cycle
//   o_MemReq/o_MemWrite    memory request / write strobe
//   o_IorD                 memory address select (0 = PC, 1 = ALUOut)
//   o_IRWrite, o_PCWrite   instruction register / PC load enables
//   o_PCSrc                PC source (00 ALU, 01 ALUOut, 10 jump)
//   o_ALUSrcA/B, o_ALUOp   ALU operand and operation selects
//   o_RegWrite/RegDst/MemtoReg  register-file write controls
//   o_State                current state code (registered)
//   o_Retired              retired-instruction count (registered)
//   o_Illegal              one-cycle pulse on an unsupported opcode
//   o_Fault                sticky memory-timeout flag (registered)
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic [5:0]       i_Opcode,
  input  logic             i_Zero,
  input  logic             i_MemReady,
  output logic             o_MemReq,
  output logic             o_MemWrite,
  output logic             o_IorD,
  output logic             o_IRWrite,
  output logic             o_PCWrite,
  output logic [1:0]       o_PCSrc,
  output logic             o_ALUSrcA,
  output logic [1:0]       o_ALUSrcB,
  output logic [1:0]       o_ALUOp,
  output logic             o_RegWrite,
  output logic             o_RegDst,
  output logic             o_MemtoReg,
  output logic [3:0]       o_State,
  output logic [CNT_W-1:0] o_Retired,
  output logic             o_Illegal,
  output logic             o_Fault
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_FAULT  = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  // The wait counter only has to reach MEM_TIMEOUT-1 before the trap fires.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  // Registered state
  state_e             state_q, state_d;
  logic [5:0]         opcode_q, opcode_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               fault_q, fault_d;

  // Decoded (ungated) controls
  state_e             state_nxt_s;
  logic               mem_req_s;
  logic               mem_write_s;
  logic               iord_s;
  logic               ir_write_s;
  logic               pc_write_s;
  logic [1:0]         pc_src_s;
  logic               alu_src_a_s;
  logic [1:0]         alu_src_b_s;
  logic [1:0]         alu_op_s;
  logic               reg_write_s;
  logic               reg_dst_s;
  logic               mem_to_reg_s;
  logic               illegal_s;
  logic               timeout_s;
  logic               retire_s;

  // State decode: control outputs and the normal next state
  always_comb begin
    state_nxt_s  = state_q;
    opcode_d     = opcode_q;
    mem_req_s    = 1'b0;
    mem_write_s  = 1'b0;
    iord_s       = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    pc_src_s     = 2'b00;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 2'b00;
    reg_write_s  = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    illegal_s    = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC + 4 is computed by the ALU while the instruction is read.
        mem_req_s   = 1'b1;
        alu_src_b_s = 2'b01;
        if (i_MemReady) begin
          ir_write_s  = 1'b1;
          pc_write_s  = 1'b1;
          state_nxt_s = S_DECODE;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed here into ALUOut.
        alu_src_b_s = 2'b11;
        opcode_d    = i_Opcode;
        case (i_Opcode)
          OP_RTYPE:     state_nxt_s = S_EXEC;
          OP_LW, OP_SW: state_nxt_s = S_MEMADR;
          OP_BEQ, OP_BNE: state_nxt_s = S_BRANCH;
          OP_J:         state_nxt_s = S_JUMP;
          OP_ADDI:      state_nxt_s = S_ADDIEX;
          default: begin
            illegal_s   = 1'b1;
            state_nxt_s = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        if (opcode_q == OP_SW) begin
          state_nxt_s = S_MEMWR;
        end else begin
          state_nxt_s = S_MEMRD;
        end
      end
      S_MEMRD: begin
        mem_req_s = 1'b1;
        iord_s    = 1'b1;
        if (i_MemReady) begin
          state_nxt_s = S_MEMWB;
        end else begin
          state_nxt_s = S_MEMRD;
        end
      end
      S_MEMWB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        state_nxt_s  = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_s   = 1'b1;
        mem_write_s = 1'b1;
        iord_s      = 1'b1;
        if (i_MemReady) begin
          state_nxt_s = S_FETCH;
        end else begin
          state_nxt_s = S_MEMWR;
        end
      end
      S_EXEC: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = 2'b10;
        state_nxt_s = S_RWB;
      end
      S_RWB: begin
        reg_write_s = 1'b1;
        reg_dst_s   = 1'b1;
        state_nxt_s = S_FETCH;
      end
      S_BRANCH: begin
        // Uses the opcode captured in DECODE; i_Opcode may have moved on.
        alu_src_a_s = 1'b1;
        alu_op_s    = 2'b01;
        pc_src_s    = 2'b01;
        pc_write_s  = ((opcode_q == OP_BEQ) &  i_Zero) |
                      ((opcode_q == OP_BNE) & ~i_Zero);
        state_nxt_s = S_FETCH;
      end
      S_JUMP: begin
        pc_src_s    = 2'b10;
        pc_write_s  = 1'b1;
        state_nxt_s = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        state_nxt_s = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_s = 1'b1;
        state_nxt_s = S_FETCH;
      end
      S_FAULT: begin
        state_nxt_s = S_FAULT;
      end
      default: begin
        state_nxt_s = S_FETCH;
      end
    endcase
  end

  // Timeout fires on the MEM_TIMEOUT-th consecutive unanswered request cycle;
  // a ready arriving on that same cycle still wins.
  assign timeout_s = (MEM_TIMEOUT != 0) && mem_req_s && !i_MemReady &&
                     (wait_q == WAIT_LAST);
  assign state_d   = timeout_s ? S_FAULT : state_nxt_s;
  assign wait_d    = (mem_req_s && !i_MemReady && !timeout_s && (MEM_TIMEOUT != 0))
                     ? (wait_q + WAIT_W'(1)) : '0;
  assign fault_d   = fault_q | timeout_s;

  // Only completed instructions retire; illegal restarts come from DECODE.
  assign retire_s  = (state_d == S_FETCH) &&
                     (state_q inside {S_MEMWB, S_MEMWR, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB});
  assign retired_d = retire_s ? (retired_q + CNT_W'(1)) : retired_q;

  // State, latched opcode, wait counter, retire counter and fault flag
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= S_FETCH;
      opcode_q  <= 6'h00;
      wait_q    <= '0;
      retired_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
    end
  end

  // Controls are forced low while reset is held, even though the state
  // register already reads FETCH (which would otherwise request memory).
  assign o_MemReq   = mem_req_s    & i_Rst_n;
  assign o_MemWrite = mem_write_s  & i_Rst_n;
  assign o_IorD     = iord_s       & i_Rst_n;
  assign o_IRWrite  = ir_write_s   & i_Rst_n;
  assign o_PCWrite  = pc_write_s   & i_Rst_n;
  assign o_PCSrc    = pc_src_s     & {2{i_Rst_n}};
  assign o_ALUSrcA  = alu_src_a_s  & i_Rst_n;
  assign o_ALUSrcB  = alu_src_b_s  & {2{i_Rst_n}};
  assign o_ALUOp    = alu_op_s     & {2{i_Rst_n}};
  assign o_RegWrite = reg_write_s  & i_Rst_n;
  assign o_RegDst   = reg_dst_s    & i_Rst_n;
  assign o_MemtoReg = mem_to_reg_s & i_Rst_n;
  assign o_Illegal  = illegal_s    & i_Rst_n;

  assign o_State    = state_q;
  assign o_Retired  = retired_q;
  assign o_Fault    = fault_q;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Drives the control unit instruction by instruction. The reference model
// describes each instruction as the list of states it visits (from the
// cycle-count table), stalls on the memory states while ready is low, and
// counts retirements/timeouts at instruction level. Expected control outputs
// per state come from the output table.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMRD = 3;
  localparam int ST_MEMWB = 4, ST_MEMWR = 5, ST_EXEC = 6, ST_RWB = 7;
  localparam int ST_BRANCH = 8, ST_JUMP = 9, ST_ADDIEX = 10, ST_ADDIWB = 11;
  localparam int ST_FAULT = 15;

  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_J = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_BAD = 6'h3F;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [5:0]       opcode = 6'h00;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_write, iord, ir_write, pc_write;
  logic [1:0]       pc_src, src_b, alu_op;
  logic             src_a, reg_write, reg_dst, mem_to_reg, illegal, fault_o;
  logic [3:0]       state_o;
  logic [CNT_W-1:0] retired_o;
  logic [16:0]      obs_ctrl;

  int checks = 0;
  int failures = 0;

  // reference model
  int         path[$];
  int         idx = 0;
  int         waits = 0;
  int         exp_retired = 0;
  logic       exp_fault = 1'b0;
  logic       done = 1'b1;
  logic [5:0] cur_op = 6'h00;

  multicycle_control #(.CNT_W(CNT_W), .MEM_TIMEOUT(TIMEOUT)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Opcode(opcode), .i_Zero(zero),
    .i_MemReady(mem_ready), .o_MemReq(mem_req), .o_MemWrite(mem_write),
    .o_IorD(iord), .o_IRWrite(ir_write), .o_PCWrite(pc_write), .o_PCSrc(pc_src),
    .o_ALUSrcA(src_a), .o_ALUSrcB(src_b), .o_ALUOp(alu_op),
    .o_RegWrite(reg_write), .o_RegDst(reg_dst), .o_MemtoReg(mem_to_reg),
    .o_State(state_o), .o_Retired(retired_o), .o_Illegal(illegal),
    .o_Fault(fault_o)
  );

  assign obs_ctrl = {mem_req, mem_write, iord, ir_write, pc_write, pc_src,
                     src_a, src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_BNE) || (op == OP_J) || (op == OP_ADDI);
  endfunction

  function automatic int base_cycles(input logic [5:0] op);
    case (op)
      OP_R:           return 4;
      OP_LW:          return 5;
      OP_SW:          return 4;
      OP_BEQ, OP_BNE: return 3;
      OP_J:           return 3;
      OP_ADDI:        return 4;
      default:        return 2;
    endcase
  endfunction

  // Output table: {MemReq,MemWrite,IorD,IRWrite,PCWrite,PCSrc,SrcA,SrcB,ALUOp,RegWrite,RegDst,MemtoReg,Illegal}
  function automatic logic [16:0] exp_ctrl(input int st, input logic rdy, input logic zr,
                                           input logic [5:0] op_in, input logic [5:0] op_lat);
    logic mreq = 1'b0, mwr = 1'b0, io = 1'b0, irw = 1'b0, pcw = 1'b0, sa = 1'b0;
    logic rw = 1'b0, rd = 1'b0, m2r = 1'b0, ill = 1'b0;
    logic [1:0] pcs = 2'b00, sb = 2'b00, alu = 2'b00;
    case (st)
      ST_FETCH:  begin mreq = 1'b1; sb = 2'b01; irw = rdy; pcw = rdy; end
      ST_DECODE: begin sb = 2'b11; ill = !is_legal(op_in); end
      ST_MEMADR: begin sa = 1'b1; sb = 2'b10; end
      ST_MEMRD:  begin mreq = 1'b1; io = 1'b1; end
      ST_MEMWB:  begin rw = 1'b1; m2r = 1'b1; end
      ST_MEMWR:  begin mreq = 1'b1; mwr = 1'b1; io = 1'b1; end
      ST_EXEC:   begin sa = 1'b1; alu = 2'b10; end
      ST_RWB:    begin rw = 1'b1; rd = 1'b1; end
      ST_BRANCH: begin
        sa = 1'b1; alu = 2'b01; pcs = 2'b01;
        pcw = ((op_lat == OP_BEQ) && zr) || ((op_lat == OP_BNE) && !zr);
      end
      ST_JUMP:   begin pcs = 2'b10; pcw = 1'b1; end
      ST_ADDIEX: begin sa = 1'b1; sb = 2'b10; end
      ST_ADDIWB: begin rw = 1'b1; end
      default:   begin end
    endcase
    return {mreq, mwr, io, irw, pcw, pcs, sa, sb, alu, rw, rd, m2r, ill};
  endfunction

  task automatic set_path(input logic [5:0] op);
    path.delete();
    path.push_back(ST_FETCH);
    path.push_back(ST_DECODE);
    case (op)
      OP_R:    begin path.push_back(ST_EXEC); path.push_back(ST_RWB); end
      OP_LW:   begin path.push_back(ST_MEMADR); path.push_back(ST_MEMRD); path.push_back(ST_MEMWB); end
      OP_SW:   begin path.push_back(ST_MEMADR); path.push_back(ST_MEMWR); end
      OP_BEQ, OP_BNE: path.push_back(ST_BRANCH);
      OP_J:    path.push_back(ST_JUMP);
      OP_ADDI: begin path.push_back(ST_ADDIEX); path.push_back(ST_ADDIWB); end
      default: begin end
    endcase
  endtask

  function automatic int model_state();
    if (exp_fault) return ST_FAULT;
    if (done) return ST_FETCH;
    return path[idx];
  endfunction

  // One clock: drive at negedge, check before posedge, advance model after it.
  task automatic cycle(input logic rdy, input logic zr);
    int st;
    logic z;
    logic [5:0] op_drv;
    st     = model_state();
    z      = (st == ST_BRANCH) ? zr : 1'($urandom);
    op_drv = (st == ST_DECODE) ? cur_op : 6'($urandom);
    mem_ready = rdy; zero = z; opcode = op_drv;
    #1;
    chk($sformatf("ctrl_st%0d", st), 32'(obs_ctrl), 32'(exp_ctrl(st, rdy, z, op_drv, cur_op)));
    chk("state", 32'(state_o), 32'(st));
    chk("retired", 32'(retired_o), 32'(exp_retired));
    chk("fault", 32'(fault_o), 32'(exp_fault));
    @(posedge clk);
    if (exp_fault) begin
    end else if ((st == ST_FETCH || st == ST_MEMRD || st == ST_MEMWR) && !rdy) begin
      waits++;
      if (waits == TIMEOUT) exp_fault = 1'b1;
    end else begin
      waits = 0;
      if (st == ST_DECODE && !is_legal(cur_op)) begin
        done = 1'b1;
      end else begin
        idx++;
        if (idx == path.size()) begin
          done = 1'b1;
          exp_retired = (exp_retired + 1) % (1 << CNT_W);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic zr, input int fhold, input int dhold);
    int st;
    int ncyc;
    logic rdy;
    ncyc = 0;
    cur_op = op; set_path(op); idx = 0; done = 1'b0; waits = 0;
    for (int k = 0; k < 64; k++) begin
      if (done || exp_fault) break;
      st = model_state();
      if (st == ST_FETCH) rdy = (waits >= fhold);
      else if (st == ST_MEMRD || st == ST_MEMWR) rdy = (waits >= dhold);
      else rdy = 1'($urandom);
      cycle(rdy, zr);
      ncyc++;
    end
    if (!exp_fault) begin
      chk("instr_done", 32'(done), 32'd1);
      chk($sformatf("cycles_op%02h", op), 32'(ncyc),
          32'(base_cycles(op) + fhold + ((op == OP_LW || op == OP_SW) ? dhold : 0)));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'($urandom); opcode = 6'($urandom); zero = 1'($urandom);
    #1;
    chk("rst_ctrl", 32'(obs_ctrl), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_retired", 32'(retired_o), 32'd0);
    chk("rst_fault", 32'(fault_o), 32'd0);
    repeat (2) @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk("rst_ctrl_held", 32'(obs_ctrl), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_retired = 0; exp_fault = 1'b0; waits = 0; done = 1'b1; idx = 0; path.delete();
  endtask

  initial begin
    logic [5:0] rop;
    int pick;
    logic [5:0] legal_ops [7];
    legal_ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI};

    @(negedge clk);
    do_reset();

    // R-type, zero-wait memory
    run_instr(OP_R, 1'b0, 0, 0);
    chk("rtype_retired", 32'(retired_o), 32'd1);
    // lw with three wait cycles in MEMRD
    run_instr(OP_LW, 1'b0, 0, 3);
    // sw, addi
    run_instr(OP_SW, 1'b0, 1, 2);
    run_instr(OP_ADDI, 1'b1, 0, 0);
    // branches: taken/not-taken both retire
    run_instr(OP_BEQ, 1'b1, 0, 0);
    run_instr(OP_BEQ, 1'b0, 0, 0);
    run_instr(OP_BNE, 1'b1, 0, 0);
    run_instr(OP_BNE, 1'b0, 0, 0);
    // illegal opcode
    run_instr(OP_BAD, 1'b0, 0, 0);
    // ready on the last allowed wait cycle of FETCH
    run_instr(OP_J, 1'b0, TIMEOUT - 1, 0);
    run_instr(OP_LW, 1'b0, TIMEOUT - 1, TIMEOUT - 1);

    // random mix
    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 7);
      if (pick < 7) begin
        rop = legal_ops[pick];
      end else begin
        rop = 6'($urandom);
        while (is_legal(rop)) rop = 6'($urandom);
      end
      run_instr(rop, 1'($urandom), $urandom_range(0, TIMEOUT - 1), $urandom_range(0, TIMEOUT - 1));
    end

    // FETCH timeout -> FAULT, held until reset
    do_reset();
    run_instr(OP_R, 1'b0, 100, 0);
    chk("fetch_timeout_fault", 32'(exp_fault), 32'd1);
    for (int n = 0; n < 4; n++) cycle(1'($urandom), 1'b0);
    chk("fault_sticky", 32'(fault_o), 32'd1);

    // MEMWR timeout
    do_reset();
    run_instr(OP_SW, 1'b0, 0, 100);
    for (int n = 0; n < 2; n++) cycle(1'b1, 1'b0);

    // retired counter wrap
    do_reset();
    for (int n = 0; n < 16; n++) run_instr(OP_J, 1'b0, 0, 0);
    chk("retired_wrap", 32'(retired_o), 32'd0);

    // asynchronous reset in the middle of a stalled lw
    run_instr(OP_ADDI, 1'b0, 0, 0);
    cur_op = OP_LW; set_path(OP_LW); idx = 0; done = 1'b0; waits = 0;
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    mem_ready = 1'b0;
    #2;
    chk("pre_abort_state", 32'(state_o), 32'(ST_MEMRD));
    rst_n = 1'b0;
    #1;
    chk("abort_state", 32'(state_o), 32'd0);
    chk("abort_retired", 32'(retired_o), 32'd0);
    chk("abort_ctrl", 32'(obs_ctrl), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_retired = 0; exp_fault = 1'b0; waits = 0; done = 1'b1; idx = 0; path.delete();
    run_instr(OP_R, 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multi-cycle control unit for the MIPS core: the next-generation replacement for the single-cycle `Control` decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states, so the datapath can share one ALU and one memory port. It stalls on a memory ready handshake and traps illegal opcodes and memory timeouts. It also keeps a retired-instruction counter for the seven-segment display path.

## Interface
- CNT_W, 32, width of retired-instruction counter
- MEM_TIMEOUT, 16, maximum consecutive wait cycles per memory access; 0 disables the timeout
- i_Clk  in  1  rising-edge clock
- i_Rst_n  in  1  asynchronous, active-low reset
- i_Opcode  in  6  instruction[31:26], valid from DECODE onward
- i_Zero  in  1  ALU zero flag
- i_MemReady  in  1  memory completes the current request this cycle
- o_MemReq  out  1  memory request
- o_MemWrite  out  1  request is a write
- o_IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- o_IRWrite  out  1  load instruction register
- o_PCWrite  out  1  load PC (branch condition already resolved)
- o_PCSrc  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump address
- o_ALUSrcA  out  1  0 = PC, 1 = reg A
- o_ALUSrcB  out  2  00 = reg B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- o_ALUOp  out  2  00 = add, 01 = sub, 10 = funct field
- o_RegWrite, o_RegDst, o_MemtoReg  out  1 each  register-file write controls
- o_State  out  4  current state code
- o_Retired  out  CNT_W  retired-instruction count
- o_Illegal  out  1  one-cycle pulse on an unsupported opcode
- o_Fault  out  1  sticky memory-timeout flag

## Operation
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, FAULT=15. Codes 12-14 are unused and go to FETCH.
- Any output not listed for a state is 0.
- FETCH
  - Outputs: MemReq=1, IorD=0, SrcA=0, SrcB=01, ALUOp=00.
  - On i_MemReady: IRWrite=1 and PCWrite=1 (PCSrc=00) in the same cycle, then go to DECODE.
  - Otherwise remain in FETCH.
- DECODE
  - Outputs: SrcA=0, SrcB=11, ALUOp=00.
  - Next state by opcode: 0x00 -> EXEC, 0x23/0x2B -> MEMADR, 0x04/0x05 -> BRANCH, 0x02 -> JUMP, 0x08 -> ADDIEX.
  - Any other opcode -> FETCH, with o_Illegal=1 for this cycle.
  - The opcode is latched internally in DECODE.
- MEMADR
  - Outputs: SrcA=1, SrcB=10, ALUOp=00.
  - Next state: MEMRD for lw, MEMWR for sw.
- MEMRD
  - Outputs: MemReq=1, IorD=1.
  - On i_MemReady -> MEMWB.
- MEMWB
  - Outputs: RegWrite=1, RegDst=0, MemtoReg=1.
  - Next state: FETCH.
- MEMWR
  - Outputs: MemReq=1, MemWrite=1, IorD=1.
  - On i_MemReady -> FETCH.
- EXEC
  - Outputs: SrcA=1, SrcB=00, ALUOp=10.
  - Next state: RWB.
- RWB
  - Outputs: RegWrite=1, RegDst=1.
  - Next state: FETCH.
- BRANCH
  - Outputs: SrcA=1, SrcB=00, ALUOp=01, PCSrc=01.
  - PCWrite = (beq & i_Zero) | (bne & ~i_Zero).
  - Next state: FETCH.
- JUMP
  - Outputs: PCSrc=10, PCWrite=1.
  - Next state: FETCH.
- ADDIEX
  - Outputs: SrcA=1, SrcB=10, ALUOp=00.
  - Next state: ADDIWB.
- ADDIWB
  - Outputs: RegWrite=1, RegDst=0.
  - Next state: FETCH.
- Timeout
  - The wait counter counts consecutive cycles with MemReq=1 and i_MemReady=0.
  - It clears on i_MemReady or on leaving the state.
  - When the counter equals MEM_TIMEOUT-1 and i_MemReady=0, go to FAULT. i_MemReady on the MEM_TIMEOUT-th wait cycle is still accepted.
- FAULT
  - All control outputs are 0 and o_Fault=1.
  - Exit only by reset.
- Retire
  - o_Retired increments by 1 on each transition into FETCH from MEMWB, MEMWR, RWB, BRANCH, JUMP or ADDIWB.
  - Taken and not-taken branches both count.
  - Illegal opcodes and faults do not count.
  - The counter wraps modulo 2^CNT_W.

## Timing
- Reset
  - While i_Rst_n=0: state=FETCH, o_Retired=0, o_Fault=0, wait counter=0, and all control outputs are forced to 0 (o_MemReq=0).
  - The first request is issued in the first cycle after release.
- Assertion of i_Rst_n is asynchronous and may occur mid-instruction; all in-flight state is discarded.
- Control outputs are combinational from the state register. IRWrite, PCWrite and o_Illegal additionally depend on i_MemReady, i_Zero and i_Opcode respectively.
- o_State, o_Retired and o_Fault are registered.
- Cycle counts with zero-wait memory: R-type 4, lw 5, sw 4, beq/bne 3, j 3, addi 4, illegal 2.
- Each wait cycle adds exactly one cycle to the instruction.

## Test plan
- R-type (opcode 0x00), i_MemReady tied 1 -> o_State 0,1,6,7,0; RegWrite=RegDst=1 in state 7; o_Retired 0 -> 1.
- lw (0x23), i_MemReady low for 3 cycles in MEMRD -> state 3 held 4 cycles with MemReq=IorD=1; MEMWB has RegWrite=MemtoReg=1; 8 cycles total.
- beq (0x04) with Zero=1 -> PCWrite=1, PCSrc=01 in BRANCH; beq with Zero=0 -> PCWrite=0; bne (0x05) gives the inverse; all three increment o_Retired.
- Opcode 0x3F -> o_Illegal=1 for exactly one cycle in DECODE, next state FETCH, o_Retired unchanged.
- MEM_TIMEOUT=4, i_MemReady held 0 in FETCH -> state 15 on the 5th cycle, o_Fault=1, o_MemReq=0, held until reset; a ready on the 4th wait cycle instead -> normal DECODE.
- CNT_W=4, 16 back-to-back j (0x02) -> o_Retired wraps to 0; i_Rst_n pulsed low mid-MEMRD -> o_State=0 and o_Retired=0 immediately, before the next clock edge.
